// File: rtl/msu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msu_pkg                                                      |
// | Description : Shared defaults and state typedef for the MSU result path.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package msu_pkg;

    localparam int c_axi_len     = 32;
    localparam int c_t_len       = 64;
    localparam int c_sq_out_bits = 128;

    typedef enum logic [1:0] {
        COL_IDLE    = 2'd0,
        COL_COLLECT = 2'd1,
        COL_HOLD    = 2'd2
    } collect_state_t;

endpackage : msu_pkg
`default_nettype wire

// File: rtl/msu_result_collect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msu_result_collect                                           |
// | Description : Gathers a fixed-length AXI-Stream burst from the squarer and |
// |               presents {square, iteration count} on a valid/ready port.    |
// |               Optional macro MSU_RESULT_CHECK_EN enables res_err checking.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msu_result_collect
    import msu_pkg::*;
#(
    parameter int AXI_LEN     = c_axi_len,
    parameter int T_LEN       = c_t_len,
    parameter int SQ_OUT_BITS = c_sq_out_bits
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_xfer,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [AXI_LEN-1:0]     s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [T_LEN-1:0]       exp_t,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [T_LEN-1:0]       res_t,
    output logic [SQ_OUT_BITS-1:0] res_sq,
    output logic                   res_err,
    output logic                   busy
);

    localparam int c_words  = (T_LEN + SQ_OUT_BITS) / AXI_LEN;
    localparam int c_cnt_w  = $clog2(c_words) + 1;
    localparam int c_data_w = c_words * AXI_LEN;

    collect_state_t        r_state;
    collect_state_t        w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_data_w-1:0]   r_data;
    logic [c_data_w-1:0]   w_data_shift;
    logic                  w_start;
    logic                  w_beat;
    logic                  w_last;

    // Burst length is fixed by WORDS; tkeep/tlast carry no information here.
    logic w_unused_axis;
    assign w_unused_axis = ^{s_axis_tkeep, s_axis_tlast};

    assign w_start      = (r_state == COL_IDLE) && start_xfer;
    assign w_beat       = (r_state == COL_COLLECT) && s_axis_tvalid;
    assign w_last       = (r_cnt == c_cnt_w'(c_words - 1));
    // New words enter at the top so the first word ends up in the low slice.
    assign w_data_shift = {s_axis_tdata, r_data[c_data_w-1:AXI_LEN]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= COL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COL_IDLE: begin
                if (start_xfer) begin
                    w_state_next = COL_COLLECT;
                end
            end
            COL_COLLECT: begin
                if (w_beat && w_last) begin
                    w_state_next = COL_HOLD;
                end
            end
            COL_HOLD: begin
                if (res_ready) begin
                    w_state_next = COL_IDLE;
                end
            end
            default: begin
                w_state_next = COL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end
            if (w_beat) begin
                r_cnt  <= r_cnt + c_cnt_w'(1);
                r_data <= w_data_shift;
            end
        end
    end

`ifdef MSU_RESULT_CHECK_EN
    logic [T_LEN-1:0] r_exp_t;
    logic             r_err;

    // Error is resolved on the final beat so it appears alongside res_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_t <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_exp_t <= exp_t;
                r_err   <= 1'b0;
            end
            if (w_beat && w_last) begin
                r_err <= (w_data_shift[T_LEN-1:0] != r_exp_t);
            end
        end
    end

    assign res_err = r_err;
`else
    logic w_unused_exp;
    assign w_unused_exp = ^exp_t;
    assign res_err      = 1'b0;
`endif

    assign s_axis_tready = (r_state == COL_COLLECT);
    assign res_valid     = (r_state == COL_HOLD);
    assign busy          = (r_state != COL_IDLE);
    assign res_t         = r_data[T_LEN-1:0];
    assign res_sq        = r_data[T_LEN +: SQ_OUT_BITS];

endmodule : msu_result_collect
`default_nettype wire

// File: tb/tb_msu_result_collect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msu_result_collect                                        |
// | Description : Randomized self-checking bench for msu_result_collect.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msu_result_collect;
    import msu_pkg::*;

    localparam int AXI_LEN     = c_axi_len;
    localparam int T_LEN       = c_t_len;
    localparam int SQ_OUT_BITS = c_sq_out_bits;
    localparam int WORDS       = (T_LEN + SQ_OUT_BITS) / AXI_LEN;
    localparam int VEC_W       = WORDS * AXI_LEN;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start_xfer;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [AXI_LEN-1:0]     s_axis_tdata;
    logic [AXI_LEN/8-1:0]   s_axis_tkeep;
    logic                   s_axis_tlast;
    logic [T_LEN-1:0]       exp_t;
    logic                   res_valid;
    logic                   res_ready;
    logic [T_LEN-1:0]       res_t;
    logic [SQ_OUT_BITS-1:0] res_sq;
    logic                   res_err;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    logic [AXI_LEN-1:0] q_words[$];

    msu_result_collect #(
        .AXI_LEN    (AXI_LEN),
        .T_LEN      (T_LEN),
        .SQ_OUT_BITS(SQ_OUT_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_xfer   (start_xfer),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .exp_t        (exp_t),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_t        (res_t),
        .res_sq       (res_sq),
        .res_err      (res_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: word i of the burst occupies bits [i*AXI_LEN +: AXI_LEN].
    function automatic logic [VEC_W-1:0] model_vec();
        logic [VEC_W-1:0] v = '0;
        for (int i = 0; i < WORDS; i++) begin
            v[i*AXI_LEN +: AXI_LEN] = q_words[i];
        end
        return v;
    endfunction

    function automatic logic model_err(input logic [T_LEN-1:0] et);
        logic [VEC_W-1:0] v = model_vec();
`ifdef MSU_RESULT_CHECK_EN
        return (v[T_LEN-1:0] != et);
`else
        return 1'b0 & (v[0] ^ et[0]);
`endif
    endfunction

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic start_burst(input logic [T_LEN-1:0] et);
        exp_t      = et;
        start_xfer = 1'b1;
        @(posedge clk); #1;
        start_xfer = 1'b0;
        exp_t      = T_LEN'($urandom);
    endtask

    task automatic send_words(input int first, input int count, input int gap);
        int n;
        for (int i = first; i < first + count; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = q_words[i];
            s_axis_tlast  = (i == WORDS - 1);
            n = 0;
            @(negedge clk);
            while (!s_axis_tready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!s_axis_tready) begin
                checks++;
                errors++;
                $display("FAIL beat_wait: tready=%0b after %0d cycles, required 1", s_axis_tready, n);
            end
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = AXI_LEN'($urandom);
            if (i != first + count - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic fill_random();
        q_words.delete();
        for (int i = 0; i < WORDS; i++) q_words.push_back(AXI_LEN'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({res_valid, s_axis_tready, busy, res_err} !== 4'b0000 || res_t !== '0 || res_sq !== '0) begin
            errors++;
            $display("FAIL reset_state: valid/tready/busy/err=%b t=%h sq=%h, required 0000 and zero data",
                     {res_valid, s_axis_tready, busy, res_err}, res_t, res_sq);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [VEC_W-1:0] v;
        q_words.delete();
        for (int i = 1; i <= WORDS; i++) q_words.push_back(AXI_LEN'(i));
        start_burst(T_LEN'(0));
        @(negedge clk);
        checks++;
        if ({s_axis_tready, busy, res_valid} !== 3'b110) begin
            errors++;
            $display("FAIL basic_collect_state: tready/busy/valid=%b, required 110", {s_axis_tready, busy, res_valid});
        end
        @(posedge clk); #1;
        send_words(0, WORDS, 0);
        @(negedge clk);
        v = model_vec();
        checks++;
        if (res_valid !== 1'b1 || res_t !== 64'h0000000200000001 ||
            res_sq !== 128'h00000006000000050000000400000003 || v[T_LEN-1:0] !== res_t) begin
            errors++;
            $display("FAIL basic_result: valid=%0b t=%h sq=%h, required 1 t=%h sq=%h",
                     res_valid, res_t, res_sq, 64'h0000000200000001, 128'h00000006000000050000000400000003);
        end
        release_result();
        @(negedge clk);
        checks++;
        if ({res_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_release: valid/busy=%b, required 00", {res_valid, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gapped();
        q_words.delete();
        for (int i = 1; i <= WORDS; i++) q_words.push_back(AXI_LEN'(i));
        start_burst(T_LEN'(0));
        send_words(0, WORDS - 1, 1);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL gapped_not_early: valid=%0b tready=%0b, required 0 and 1", res_valid, s_axis_tready);
        end
        @(posedge clk); #1;
        send_words(WORDS - 1, 1, 0);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || {res_sq, res_t} !== model_vec()) begin
            errors++;
            $display("FAIL gapped_result: valid=%0b data=%h, required 1 data=%h", res_valid, {res_sq, res_t}, model_vec());
        end
        release_result();
    endtask

    task automatic test_backpressure();
        logic [T_LEN-1:0]       hold_t;
        logic [SQ_OUT_BITS-1:0] hold_sq;
        logic                   hold_err;
        fill_random();
        start_burst(T_LEN'($urandom));
        send_words(0, WORDS, 0);
        @(negedge clk);
        hold_t   = res_t;
        hold_sq  = res_sq;
        hold_err = res_err;
        checks++;
        if (res_valid !== 1'b1 || {res_sq, res_t} !== model_vec()) begin
            errors++;
            $display("FAIL bp_result: valid=%0b data=%h, required 1 data=%h", res_valid, {res_sq, res_t}, model_vec());
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start_xfer    = c[0];
            s_axis_tvalid = ~c[0];
            s_axis_tdata  = AXI_LEN'($urandom);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b1 ||
                res_t !== hold_t || res_sq !== hold_sq || res_err !== hold_err) begin
                errors++;
                $display("FAIL bp_stable[%0d]: valid=%0b tready=%0b t=%h sq=%h, required 1 0 t=%h sq=%h",
                         c, res_valid, s_axis_tready, res_t, res_sq, hold_t, hold_sq);
            end
        end
        @(posedge clk); #1;
        start_xfer    = 1'b0;
        s_axis_tvalid = 1'b0;
        release_result();
        @(negedge clk);
        checks++;
        if ({res_valid, s_axis_tready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL bp_release: valid/tready/busy=%b, required 000", {res_valid, s_axis_tready, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        fill_random();
        start_burst(T_LEN'(0));
        send_words(0, 3, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({res_valid, s_axis_tready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_state: valid/tready/busy=%b, required 000", {res_valid, s_axis_tready, busy});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        fill_random();
        start_burst(T_LEN'(0));
        send_words(0, WORDS, 0);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || {res_sq, res_t} !== model_vec()) begin
            errors++;
            $display("FAIL midreset_result: valid=%0b data=%h, required 1 data=%h", res_valid, {res_sq, res_t}, model_vec());
        end
        release_result();
    endtask

    task automatic test_check();
        logic req;
        for (int k = 0; k < 2; k++) begin
            fill_random();
            q_words[0] = (k == 0) ? AXI_LEN'(5) : AXI_LEN'(4);
            q_words[1] = '0;
`ifdef MSU_RESULT_CHECK_EN
            req = (k == 1);
`else
            req = 1'b0;
`endif
            start_burst(T_LEN'(5));
            send_words(0, WORDS, 0);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_err !== req) begin
                errors++;
                $display("FAIL check_err[%0d]: valid=%0b err=%0b, required 1 %0b", k, res_valid, res_err, req);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [T_LEN-1:0] et;
        logic [VEC_W-1:0] v;
        for (int k = 0; k < 6; k++) begin
            fill_random();
            v  = model_vec();
            et = ($urandom_range(0, 1) == 1) ? v[T_LEN-1:0] : T_LEN'({$urandom, $urandom});
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            start_burst(et);
            send_words(0, WORDS, $urandom_range(0, 3));
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || {res_sq, res_t} !== v || res_err !== model_err(et)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%0b err=%0b data=%h, required 1 %0b %h",
                         k, res_valid, res_err, {res_sq, res_t}, model_err(et), v);
            end
            @(posedge clk); #1;
            release_result();
        end
    endtask

    initial begin
        reset         = 1'b1;
        start_xfer    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        exp_t         = '0;
        res_ready     = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_mid_reset();
        test_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_msu_result_collect
`default_nettype wire

// File: doc/msu_result_collect.md
MSU_RESULT_COLLECT -- requirements
Module: msu_result_collect

Interface
REQ-001 Parameter AXI_LEN, default 32: stream word width in bits.
REQ-002 Parameter T_LEN, default 64: iteration-count field width.
REQ-003 Parameter SQ_OUT_BITS, default 128: squarer result width.
REQ-004 Port clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start_xfer, input, 1: one-cycle pulse from the squarer unit announcing an imminent result burst.
REQ-007 Port s_axis_tvalid, input, 1: incoming word valid.
REQ-008 Port s_axis_tready, output, 1: collector accepts a word.
REQ-009 Port s_axis_tdata, input, AXI_LEN: incoming word.
REQ-010 Port s_axis_tkeep, input, AXI_LEN/8: ignored.
REQ-011 Port s_axis_tlast, input, 1: ignored; burst end is determined by word count.
REQ-012 Port exp_t, input, T_LEN: expected final iteration count.
REQ-013 Port res_valid, output, 1: assembled result available.
REQ-014 Port res_ready, input, 1: consumer takes the result.
REQ-015 Port res_t, output, T_LEN: received iteration count.
REQ-016 Port res_sq, output, SQ_OUT_BITS: received square.
REQ-017 Port res_err, output, 1: iteration-count mismatch flag.
REQ-018 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 WORDS = (T_LEN+SQ_OUT_BITS)/AXI_LEN (6 at defaults); T_LEN and SQ_OUT_BITS SHALL be multiples of AXI_LEN.
REQ-020 The FSM SHALL have exactly three states: IDLE, COLLECT, HOLD.
REQ-021 In IDLE, start_xfer SHALL move the FSM to COLLECT next cycle, clear the word counter, and sample exp_t.
REQ-022 In COLLECT, s_axis_tready SHALL be 1; it SHALL be 0 in IDLE and HOLD.
REQ-023 Each beat (tvalid and tready) SHALL shift the word into the MSB end of a WORDS*AXI_LEN register and increment the counter, so the first word lands at bits [AXI_LEN-1:0].
REQ-024 A beat with counter == WORDS-1 SHALL move the FSM to HOLD; res_valid SHALL be 1 on the following cycle (1-cycle latency from the last beat).
REQ-025 res_t SHALL be register bits [T_LEN-1:0]; res_sq SHALL be the next SQ_OUT_BITS bits.
REQ-026 In HOLD, res_valid, res_t, res_sq, and res_err SHALL stay stable until res_ready is sampled high; the FSM then returns to IDLE and res_valid drops next cycle.
REQ-027 start_xfer SHALL be ignored in COLLECT and HOLD.
REQ-028 Idle cycles in COLLECT (tvalid low) SHALL not advance the counter; there is no timeout.
REQ-029 The counter SHALL be C_XFER_SIZE_WIDTH-independent, sized clog2(WORDS)+1, and SHALL never wrap.

Reset
REQ-030 When reset is high at a clock edge, the block SHALL enter IDLE and zero the counter, data register, sampled exp_t, and res_err; res_valid, s_axis_tready, and busy SHALL be 0 in the following cycle, including when reset occurs mid-burst or in HOLD.

Configuration
REQ-031 With MSU_RESULT_CHECK_EN defined, res_err SHALL be registered as (received t field != sampled exp_t) and presented together with res_valid.
REQ-032 Without MSU_RESULT_CHECK_EN, res_err SHALL be constant 0, exp_t SHALL be unused, and the port list SHALL be unchanged.

Structure
REQ-033 The shared package msu_pkg SHALL hold the default AXI_LEN/T_LEN/SQ_OUT_BITS constants and the collector state typedef.
REQ-034 No sub-module is natural here; the block SHALL be implemented flat.

Verification
REQ-035 Basic burst: start_xfer, then 6 back-to-back words 0x1..0x6 -> res_valid 1 cycle after the 6th beat; res_t=0x0000000200000001; res_sq=0x00000006000000050000000400000003.
REQ-036 Gapped stream: tvalid toggles every other cycle over 6 words -> the same result as REQ-035; the counter advances only on beats.
REQ-037 Backpressure: res_ready held low 10 cycles in HOLD while extra start_xfer and tvalid pulses arrive -> outputs stable, tready 0, no state change; res_valid drops the cycle after res_ready.
REQ-038 Mid-burst reset after 3 beats, then a fresh 6-word burst -> only the new words appear in the result; res_valid stays 0 during reset.
REQ-039 Check (macro on): exp_t=5, received t=5 -> res_err=0; received t=4 -> res_err=1. With the macro off -> res_err=0 in both cases.
